// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__bist_pkg.sv - shared states, pattern table and widths for the NOR2 BIST
package gf180mcu_fd_sc_mcu7t5v0__bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } bist_state_t;

    localparam int ERR_CNT_W = 8;

    // Entry i holds {A2,A1} for pattern i; EXP_ZN bit i is the ideal NOR2 response.
    localparam logic [7:0] PAT_TABLE = {2'b11, 2'b10, 2'b01, 2'b00};
    localparam logic [3:0] EXP_ZN    = 4'b0001;

    function automatic logic [1:0] pat_of(input logic [1:0] idx);
        return PAT_TABLE[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic exp_of(input logic [1:0] idx);
        return EXP_ZN[idx];
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt.sv - settle countdown, expired on the last settle cycle
module gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [3:0] SETTLE_CYC,
    output logic       expired
);

    logic [3:0] r_cnt;

    // Loaded in APPLY so that the count reaches zero on the SETTLE_CYC-th settle cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 4'd0;
        end else if (load) begin
            r_cnt <= SETTLE_CYC - 4'd1;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign expired = (r_cnt == 4'd0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor2_bist.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__nor2_bist.sv - NOR2 truth-table BIST; ERR_CNT via GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
module gf180mcu_fd_sc_mcu7t5v0__nor2_bist
    import gf180mcu_fd_sc_mcu7t5v0__bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int ITER       = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 ZN_DUT,
    output logic                 A1_DUT,
    output logic                 A2_DUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [3:0]           FAIL_VEC,
`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
    output logic [ERR_CNT_W-1:0] ERR_CNT,
`endif
    inout  wire                  VDD,
    inout  wire                  VSS
);

    localparam logic [3:0] SETTLE_L   = 4'(SETTLE_CYC);
    localparam logic [7:0] LAST_SWEEP = 8'(ITER - 1);

    bist_state_t r_state, w_state_nxt;
    logic [1:0]  r_pat, w_pat_nxt;
    logic [7:0]  r_sweep, w_sweep_nxt;
    logic [3:0]  r_fail_vec, w_fail_nxt;
    logic        r_pass, w_pass_nxt;
    logic        w_load, w_expired, w_mismatch, w_accept, w_drive;
    logic [1:0]  w_pat_bits;
    logic        w_unused;

    gf180mcu_fd_sc_mcu7t5v0__bist_settle_cnt u_settle (
        .CLK        (CLK),
        .RST        (RST),
        .load       (w_load),
        .SETTLE_CYC (SETTLE_L),
        .expired    (w_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_pat      <= 2'd0;
            r_sweep    <= 8'd0;
            r_fail_vec <= 4'd0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pat      <= w_pat_nxt;
            r_sweep    <= w_sweep_nxt;
            r_fail_vec <= w_fail_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_sweep_nxt = r_sweep;
        w_fail_nxt  = r_fail_vec;
        w_pass_nxt  = r_pass;
        w_load      = 1'b0;
        w_mismatch  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_APPLY;
                    w_pat_nxt   = 2'd0;
                    w_sweep_nxt = 8'd0;
                    w_fail_nxt  = 4'd0;
                    w_pass_nxt  = 1'b0;
                end
            end
            ST_APPLY: begin
                w_load      = 1'b1;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_expired) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_mismatch = (ZN_DUT != exp_of(r_pat));
                if (w_mismatch) begin
                    w_fail_nxt[r_pat] = 1'b1;
                end
                w_pat_nxt   = r_pat + 2'd1;
                w_state_nxt = ST_APPLY;
                if (r_pat == 2'd3) begin
                    w_sweep_nxt = r_sweep + 8'd1;
                    if (r_sweep == LAST_SWEEP) begin
                        w_state_nxt = ST_DONE;
                        w_pass_nxt  = (w_fail_nxt == 4'd0);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort discards any in-flight sample so the result flags stay frozen.
        if (ABORT && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_fail_nxt  = r_fail_vec;
            w_pass_nxt  = 1'b0;
            w_mismatch  = 1'b0;
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_cnt <= '0;
        end else if (w_accept) begin
            r_err_cnt <= '0;
        end else if (w_mismatch && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

    assign w_drive    = (r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign w_pat_bits = w_drive ? pat_of(r_pat) : 2'b00;
    assign A1_DUT     = w_pat_bits[0];
    assign A2_DUT     = w_pat_bits[1];
    assign BUSY       = (r_state != ST_IDLE);
    assign DONE       = (r_state == ST_DONE);
    assign PASS       = r_pass;
    assign FAIL_VEC   = r_fail_vec;
    assign w_unused   = ^{VDD, VSS, w_accept};

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor2_bist.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor2_bist.sv - self-checking bench for the NOR2 BIST (ITER=1 and ITER=100 instances)
module tb_gf180mcu_fd_sc_mcu7t5v0__nor2_bist;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic [1:0] start_v;
    logic [1:0] abort_v;
    logic [1:0] rst_v;
    logic       flip;
    int         fmode [2];

    wire [1:0] a1, a2, zn, busy, done, pass;
    wire [3:0] fv [2];
`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
    wire [7:0] ec [2];
`endif
    wire vdd, vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference run state: cycle index k counts from the first APPLY cycle.
    bit         m_act  [2];
    int         m_k    [2];
    logic [3:0] m_fv   [2];
    int         m_ec   [2];
    bit         m_pass [2];
    int         m_iter [2] = '{1, 100};

    always #5 clk = ~clk;

    function automatic logic nor_model(input logic x1, input logic x2, input int mode, input logic f);
        case (mode)
            0:       return ~(x1 | x2);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ~(x1 | x2) ^ f;
        endcase
    endfunction

    assign zn[0] = nor_model(a1[0], a2[0], fmode[0], flip);
    assign zn[1] = nor_model(a1[1], a2[1], fmode[1], flip);

    gf180mcu_fd_sc_mcu7t5v0__nor2_bist #(.SETTLE_CYC(S), .ITER(1)) u_dut0 (
        .CLK(clk), .RST(rst_v[0]), .START(start_v[0]), .ABORT(abort_v[0]), .ZN_DUT(zn[0]),
        .A1_DUT(a1[0]), .A2_DUT(a2[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
        .FAIL_VEC(fv[0]),
`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
        .ERR_CNT(ec[0]),
`endif
        .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu7t5v0__nor2_bist #(.SETTLE_CYC(S), .ITER(100)) u_dut1 (
        .CLK(clk), .RST(rst_v[1]), .START(start_v[1]), .ABORT(abort_v[1]), .ZN_DUT(zn[1]),
        .A1_DUT(a1[1]), .A2_DUT(a2[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
        .FAIL_VEC(fv[1]),
`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
        .ERR_CNT(ec[1]),
`endif
        .VDD(vdd), .VSS(vss)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_adv();
        for (int i = 0; i < 2; i++) begin
            int   per;
            int   len;
            int   p;
            logic zm;
            per = S + 2;
            len = m_iter[i] * 4 * per;
            if (rst_v[i]) begin
                m_act[i] = 0; m_k[i] = 0; m_fv[i] = 4'd0; m_ec[i] = 0; m_pass[i] = 0;
            end else if (!m_act[i]) begin
                if (start_v[i] && !abort_v[i]) begin
                    m_act[i] = 1; m_k[i] = 0; m_fv[i] = 4'd0; m_ec[i] = 0; m_pass[i] = 0;
                end
            end else if (abort_v[i]) begin
                m_act[i]  = 0;
                m_pass[i] = 0;
            end else if (m_k[i] == len) begin
                m_act[i] = 0;
            end else begin
                p = (m_k[i] / per) % 4;
                if ((m_k[i] % per) == per - 1) begin
                    zm = nor_model(p[0], p[1], fmode[i], flip);
                    if (zm != (p == 0)) begin
                        m_fv[i][p] = 1'b1;
                        if (m_ec[i] < 255) m_ec[i]++;
                    end
                end
                m_k[i]++;
                if (m_k[i] == len) m_pass[i] = (m_fv[i] == 4'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int len;
                int p;
                bit drv;
                len = m_iter[i] * 4 * (S + 2);
                p   = (m_k[i] / (S + 2)) % 4;
                drv = m_act[i] && (m_k[i] < len);
                chk($sformatf("dut%0d busy", i), int'(busy[i]), int'(m_act[i]));
                chk($sformatf("dut%0d done", i), int'(done[i]), int'(m_act[i] && (m_k[i] == len)));
                chk($sformatf("dut%0d a1", i), int'(a1[i]), drv ? p % 2 : 0);
                chk($sformatf("dut%0d a2", i), int'(a2[i]), drv ? p / 2 : 0);
                chk($sformatf("dut%0d pass", i), int'(pass[i]), int'(m_pass[i]));
                chk($sformatf("dut%0d fail_vec", i), int'(fv[i]), int'(m_fv[i]));
`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
                chk($sformatf("dut%0d err_cnt", i), int'(ec[i]), m_ec[i]);
`endif
            end
        end
    end

    task automatic step(input logic [1:0] s, input logic [1:0] a, input logic [1:0] r);
        start_v = s;
        abort_v = a;
        rst_v   = r;
        @(posedge clk);
        model_adv();
        #1;
        flip = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int i, input int max, input bit repulse, output int n);
        logic [1:0] s;
        n = 0;
        do begin
            s = (repulse && (n % 5 == 2)) ? 2'(1 << i) : 2'b00;
            step(s, 2'b00, 2'b00);
            n++;
        end while (!done[i] && n < max);
        if (!done[i]) chk($sformatf("dut%0d done timeout", i), 0, 1);
    endtask

    task automatic chk_ec(input string nm, input int i, input int exp);
`ifdef GF180MCU_FD_SC_MCU7T5V0_NOR2_BIST_ERRCNT_EN
        chk(nm, int'(ec[i]), exp);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        start_v = 2'b00; abort_v = 2'b00; rst_v = 2'b11; flip = 1'b0;
        fmode[0] = 0; fmode[1] = 2;
        step(2'b00, 2'b00, 2'b11);
        step(2'b00, 2'b00, 2'b11);
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("reset done%0d", i), int'(done[i]), 0);
            chk($sformatf("reset pass%0d", i), int'(pass[i]), 0);
            chk($sformatf("reset fail_vec%0d", i), int'(fv[i]), 0);
            chk($sformatf("reset a%0d", i), int'({a2[i], a1[i]}), 0);
            chk_ec($sformatf("reset err_cnt%0d", i), i, 0);
        end

        // Ideal run on dut0; dut1 starts its 100-sweep stuck-at-1 run alongside.
        step(2'b11, 2'b00, 2'b00);
        chk("apply busy", int'(busy[0]), 1);
        wait_done(0, 64, 1'b0, n);
        chk("ideal latency", n, 16);
        chk("ideal pass", int'(pass[0]), 1);
        chk("ideal fail_vec", int'(fv[0]), 0);
        chk_ec("ideal err_cnt", 0, 0);
        step(2'b00, 2'b00, 2'b00);
        chk("done one-cycle", int'(done[0]), 0);
        chk("pass held", int'(pass[0]), 1);

        // START re-pulsed while busy changes nothing.
        step(2'b01, 2'b00, 2'b00);
        wait_done(0, 64, 1'b1, n);
        chk("repulse latency", n, 16);
        step(2'b00, 2'b00, 2'b00);

        fmode[0] = 1;
        step(2'b01, 2'b00, 2'b00);
        wait_done(0, 64, 1'b0, n);
        chk("stuck0 pass", int'(pass[0]), 0);
        chk("stuck0 fail_vec", int'(fv[0]), 1);
        chk_ec("stuck0 err_cnt", 0, 1);
        step(2'b00, 2'b00, 2'b00);

        // Abort in sweep 0, pattern 2, first SETTLE cycle.
        fmode[0] = 0;
        step(2'b01, 2'b00, 2'b00);
        repeat (9) step(2'b00, 2'b00, 2'b00);
        chk("pat2 a1", int'(a1[0]), 0);
        chk("pat2 a2", int'(a2[0]), 1);
        step(2'b00, 2'b01, 2'b00);
        chk("abort busy", int'(busy[0]), 0);
        chk("abort a", int'({a2[0], a1[0]}), 0);
        chk("abort done", int'(done[0]), 0);
        chk("abort pass", int'(pass[0]), 0);
        seen = 0;
        repeat (20) begin
            step(2'b00, 2'b00, 2'b00);
            if (done[0]) seen++;
        end
        chk("no done after abort", seen, 0);

        // Reset mid-SAMPLE (pattern 1) after a pattern-0 mismatch.
        fmode[0] = 1;
        step(2'b01, 2'b00, 2'b00);
        repeat (7) step(2'b00, 2'b00, 2'b00);
        chk("pre-reset fail_vec", int'(fv[0]), 1);
        step(2'b00, 2'b00, 2'b01);
        chk("midrun reset busy", int'(busy[0]), 0);
        chk("midrun reset fail_vec", int'(fv[0]), 0);
        chk("midrun reset a", int'({a2[0], a1[0]}), 0);
        chk("midrun reset pass", int'(pass[0]), 0);
        chk_ec("midrun reset err_cnt", 0, 0);
        fmode[0] = 0;
        step(2'b01, 2'b00, 2'b00);
        wait_done(0, 64, 1'b0, n);
        chk("post-reset latency", n, 16);
        chk("post-reset pass", int'(pass[0]), 1);
        chk("post-reset fail_vec", int'(fv[0]), 0);
        step(2'b00, 2'b00, 2'b00);

        wait_done(1, 2000, 1'b0, n);
        chk("stuck1 fail_vec", int'(fv[1]), 14);
        chk("stuck1 pass", int'(pass[1]), 0);
        chk_ec("stuck1 err_cnt", 1, 255);
        step(2'b00, 2'b00, 2'b00);

        repeat (3000) begin
            logic [1:0] s, a, r;
            for (int i = 0; i < 2; i++) begin
                s[i] = ($urandom_range(0, 7) == 0);
                a[i] = ($urandom_range(0, 59) == 0);
                r[i] = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 49) == 0) fmode[i] = int'($urandom_range(0, 3));
            end
            step(s, a, r);
        end
        step(2'b00, 2'b00, 2'b00);
        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
